// File: rtl/data_axis_pkt_pkg.sv
// Shared types and helpers for the data_inf -> AXI-Stream packetizer.
// Holds the hold-register state enum, the counter width and the CONTAIN_LAST decoder.
package data_axis_pkt_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        HS_EMPTY = 2'd0,
        HS_DATA  = 2'd1,
        HS_TERM  = 2'd2
    } hold_state_e;

    function automatic bit is_contain_last(input string mode);
        return (mode == "ON") || (mode == "TRUE");
    endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// Minimal AXI-Stream interface carrying tdata/tlast/tkeep/tuser.
interface axi_stream_inf #(
    parameter int DSIZE = 8,
    parameter int KSIZE = (DSIZE + 7) / 8
);
    logic             tvalid;
    logic             tready;
    logic [DSIZE-1:0] tdata;
    logic             tlast;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;

    modport master (output tvalid, output tdata, output tlast, output tkeep, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tkeep, input tuser, output tready);
endinterface

// File: rtl/data_inf_c.sv
// Plain valid/ready/data beat interface used on the packetizer input side.
interface data_inf_c #(
    parameter int DSIZE = 8
);
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/pkt_beat_counter.sv
// Per-packet beat counter with terminal compare, plus the saturating idle
// counter that drives the timeout flush of a held non-terminal beat.
module pkt_beat_counter
    import data_axis_pkt_pkg::*;
#(
    parameter int PKT_LEN = 256,
    parameter int TIMEOUT = 0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic beat_acc,
    input  logic beat_flag,
    input  logic idle_inc,
    input  logic flush,
    output logic terminal,
    output logic timeout_hit
);

    localparam int               IDLE_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    assign terminal    = beat_flag || (beat_cnt_q == LAST_IDX);
    assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_MAX);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            idle_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            idle_q     <= idle_d;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (beat_acc) begin
            beat_cnt_d = terminal ? '0 : beat_cnt_q + CNT_W'(1);
        end else if (flush) begin
            beat_cnt_d = '0;
        end
    end

    // Saturates at TIMEOUT so an expired flush can wait for the output slot.
    always_comb begin
        idle_d = idle_q;
        if (beat_acc || flush) begin
            idle_d = '0;
        end else if (idle_inc && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

endmodule

// File: rtl/data_inf_to_axis_pkt.sv
// Packetizer: headerless data_inf beats in, AXI-Stream packets with generated tlast out.
// One beat sits in a hold register until its last-status is known.
module data_inf_to_axis_pkt
    import data_axis_pkt_pkg::*;
#(
    parameter int    PKT_LEN      = 256,
    parameter string CONTAIN_LAST = "OFF",
    parameter int    TIMEOUT      = 0,
    parameter int    IN_DSIZE     = 8,
    parameter int    OUT_DSIZE    = 8
) (
    input  logic          clock,
    input  logic          rst_n,
    data_inf_c.slaver     data_in_inf,
    axi_stream_inf.master axis_out,
    output logic          pkt_done,
    output logic          flush_pulse
);

    localparam bit HAS_LAST = is_contain_last(CONTAIN_LAST);
    localparam int PAY_W    = HAS_LAST ? IN_DSIZE - 1 : IN_DSIZE;

    hold_state_e          hold_q, hold_d;
    logic [OUT_DSIZE-1:0] hold_data_q, hold_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_DSIZE-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 flush_q, flush_d;

    logic [PAY_W-1:0]     pay_bits;
    logic [OUT_DSIZE-1:0] in_payload;
    logic                 in_flag;
    logic                 in_ready;
    logic                 in_acc;
    logic                 out_load_ok;
    logic                 move_out;
    logic                 move_last;
    logic                 flush_now;
    logic                 terminal;
    logic                 timeout_hit;
    logic                 idle_inc;

    assign pay_bits    = data_in_inf.data[PAY_W-1:0];
    assign in_payload  = OUT_DSIZE'(pay_bits);
    assign in_flag     = HAS_LAST && data_in_inf.data[IN_DSIZE-1];
    assign out_load_ok = !out_valid_q || axis_out.tready;
    assign in_ready    = rst_n && ((hold_q == HS_EMPTY) || out_load_ok);
    assign in_acc      = data_in_inf.valid && in_ready;
    assign idle_inc    = (hold_q == HS_DATA) && !in_acc;

    pkt_beat_counter #(
        .PKT_LEN (PKT_LEN),
        .TIMEOUT (TIMEOUT)
    ) u_beat_counter (
        .clock       (clock),
        .rst_n       (rst_n),
        .beat_acc    (in_acc),
        .beat_flag   (in_flag),
        .idle_inc    (idle_inc),
        .flush       (flush_now),
        .terminal    (terminal),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= HS_EMPTY;
            hold_data_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pkt_done_q  <= pkt_done_d;
            flush_q     <= flush_d;
        end
    end

    // A new accept always wins over a timeout expiring in the same cycle.
    always_comb begin
        hold_d      = hold_q;
        hold_data_d = hold_data_q;
        move_out    = 1'b0;
        move_last   = 1'b0;
        flush_now   = 1'b0;
        case (hold_q)
            HS_EMPTY: begin
                if (in_acc) begin
                    hold_d      = terminal ? HS_TERM : HS_DATA;
                    hold_data_d = in_payload;
                end
            end
            HS_DATA: begin
                if (in_acc) begin
                    move_out    = 1'b1;
                    hold_d      = terminal ? HS_TERM : HS_DATA;
                    hold_data_d = in_payload;
                end else if (timeout_hit && out_load_ok) begin
                    move_out  = 1'b1;
                    move_last = 1'b1;
                    flush_now = 1'b1;
                    hold_d    = HS_EMPTY;
                end
            end
            HS_TERM: begin
                if (in_acc) begin
                    move_out    = 1'b1;
                    move_last   = 1'b1;
                    hold_d      = terminal ? HS_TERM : HS_DATA;
                    hold_data_d = in_payload;
                end else if (out_load_ok) begin
                    move_out  = 1'b1;
                    move_last = 1'b1;
                    hold_d    = HS_EMPTY;
                end
            end
            default: hold_d = HS_EMPTY;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (move_out) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_last_d  = move_last;
        end else if (axis_out.tready) begin
            out_valid_d = 1'b0;
        end
        pkt_done_d = out_valid_q && axis_out.tready && out_last_q;
        flush_d    = flush_now;
    end

    assign data_in_inf.ready = in_ready;
    assign axis_out.tvalid   = out_valid_q;
    assign axis_out.tdata    = out_data_q;
    assign axis_out.tlast    = out_last_q;
    assign axis_out.tkeep    = '1;
    assign axis_out.tuser    = 1'b0;
    assign pkt_done          = pkt_done_q;
    assign flush_pulse       = flush_q;

endmodule
